// File: rtl/spio_spinnaker_link_receiver_pkg.sv
// Shared definitions for the SpiNNaker 2-of-7 link receiver: packet layout,
// flit counts and the 2-of-7 symbol code table.
package spio_spinnaker_link_receiver_pkg;

  localparam int unsigned PKT_W   = 72;
  localparam int unsigned HDR_LSB = 0;
  localparam int unsigned HDR_W   = 8;
  localparam int unsigned KEY_LSB = 8;
  localparam int unsigned KEY_W   = 32;
  localparam int unsigned PLD_LSB = 40;
  localparam int unsigned PLD_W   = 32;

  // Header bit that selects a long (payload-carrying) packet
  localparam int unsigned HDR_LONG_BIT = 1;

  localparam logic [4:0] SHORT_FLITS = 5'd10;
  localparam logic [4:0] LONG_FLITS  = 5'd18;

  localparam logic [6:0] EOP_SYM = 7'b1100000;

  localparam logic [6:0] SYM_TABLE [16] = '{
    7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
    7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
    7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
    7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001
  };

  typedef enum logic [1:0] {
    SYM_NONE,
    SYM_DATA,
    SYM_EOP,
    SYM_BAD
  } sym_kind_t;

  typedef struct packed {
    sym_kind_t  kind;
    logic [3:0] nibble;
  } sym_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RECV,
    ST_DROP
  } rx_state_t;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Fewer than two changed wires means the symbol is still in flight
  function automatic sym_t decode_sym(input logic [6:0] diff);
    sym_t s;
    s.kind   = SYM_NONE;
    s.nibble = '0;
    if (popcount7(diff) >= 3'd2) begin
      if (diff == EOP_SYM) begin
        s.kind = SYM_EOP;
      end else begin
        s.kind = SYM_BAD;
        for (int unsigned i = 0; i < 16; i++) begin
          if (diff == SYM_TABLE[i]) begin
            s.kind   = SYM_DATA;
            s.nibble = i[3:0];
          end
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/spio_spinnaker_link_sync.sv
// Two-flop synchroniser for asynchronous link wires.
module spio_spinnaker_link_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/spio_spinnaker_link_receiver.sv
// SpiNNaker 2-of-7 NRZ link receiver: decodes symbols into flits, assembles
// short/long packets and presents them on a valid/ready interface.
module spio_spinnaker_link_receiver
  import spio_spinnaker_link_receiver_pkg::*;
(
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  output logic                 FLT_ERR_OUT,
  output logic                 FRM_ERR_OUT,
  input  logic [6:0]           SL_DATA_2OF7_IN,
  output logic                 SL_ACK_OUT,
  output logic [PKT_W-1:0]     PKT_DATA_OUT,
  output logic                 PKT_VLD_OUT,
  input  logic                 PKT_RDY_IN
);

  logic [6:0]       sync_data;
  logic [6:0]       last_data;
  logic [6:0]       diff;
  sym_t             sym;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [4:0]       flit_cnt;
  logic [PKT_W-1:0] asm_buf;

  logic consume;
  logic ack_init;
  logic wr_flit;
  logic eop_clr;
  logic load_out;
  logic flt_err_c;
  logic frm_err_c;
  logic out_free;
  logic len_ok;

  spio_spinnaker_link_sync #(.WIDTH(7)) u_sync (
    .clk (CLK_IN),
    .d   (SL_DATA_2OF7_IN),
    .q   (sync_data)
  );

  always_comb begin
    diff     = sync_data ^ last_data;
    sym      = decode_sym(diff);
    out_free = !PKT_VLD_OUT || PKT_RDY_IN;
    len_ok   = ((flit_cnt == SHORT_FLITS) && !asm_buf[HDR_LSB + HDR_LONG_BIT]) ||
               ((flit_cnt == LONG_FLITS)  &&  asm_buf[HDR_LSB + HDR_LONG_BIT]);
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    ack_init  = 1'b0;
    wr_flit   = 1'b0;
    eop_clr   = 1'b0;
    load_out  = 1'b0;
    flt_err_c = 1'b0;
    frm_err_c = 1'b0;
    unique case (state)
      ST_INIT: begin
        ack_init  = 1'b1;
        state_nxt = ST_RECV;
      end
      ST_RECV: begin
        unique case (sym.kind)
          SYM_DATA: begin
            consume = 1'b1;
            if (flit_cnt == LONG_FLITS) begin
              frm_err_c = 1'b1;
              state_nxt = ST_DROP;
            end else begin
              wr_flit = 1'b1;
            end
          end
          SYM_BAD: begin
            consume   = 1'b1;
            flt_err_c = 1'b1;
            state_nxt = ST_DROP;
          end
          SYM_EOP: begin
            // A good EOP is only acked once the output register can take it
            if (!len_ok) begin
              consume   = 1'b1;
              eop_clr   = 1'b1;
              frm_err_c = 1'b1;
            end else if (out_free) begin
              consume  = 1'b1;
              eop_clr  = 1'b1;
              load_out = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_DROP: begin
        unique case (sym.kind)
          SYM_DATA: consume = 1'b1;
          SYM_BAD: begin
            consume   = 1'b1;
            flt_err_c = 1'b1;
          end
          SYM_EOP: begin
            consume   = 1'b1;
            eop_clr   = 1'b1;
            state_nxt = ST_RECV;
          end
          default: ;
        endcase
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      last_data    <= sync_data;
      flit_cnt     <= '0;
      asm_buf      <= '0;
      SL_ACK_OUT   <= 1'b0;
      PKT_DATA_OUT <= '0;
      PKT_VLD_OUT  <= 1'b0;
      FLT_ERR_OUT  <= 1'b0;
      FRM_ERR_OUT  <= 1'b0;
    end else begin
      if (consume) begin
        last_data <= sync_data;
      end
      if (consume || ack_init) begin
        SL_ACK_OUT <= ~SL_ACK_OUT;
      end
      if (wr_flit) begin
        asm_buf[{flit_cnt, 2'b00} +: 4] <= sym.nibble;
        flit_cnt                        <= flit_cnt + 5'd1;
      end
      // Clearing on every EOP leaves short-packet payload bits at zero
      if (eop_clr) begin
        asm_buf  <= '0;
        flit_cnt <= '0;
      end
      if (load_out) begin
        PKT_DATA_OUT <= asm_buf;
        PKT_VLD_OUT  <= 1'b1;
      end else if (PKT_RDY_IN) begin
        PKT_VLD_OUT  <= 1'b0;
      end
      FLT_ERR_OUT <= flt_err_c;
      FRM_ERR_OUT <= frm_err_c;
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_receiver.sv
// Scoreboard bench for the 2-of-7 link receiver: a link-side model drives
// symbols and waits for acks, a monitor checks delivered packets in order.
module tb_spio_spinnaker_link_receiver;
  import spio_spinnaker_link_receiver_pkg::*;

  localparam logic [6:0] TB_EOP = 7'b1100000;
  localparam logic [6:0] TB_BAD = 7'b0000111;

  logic        tb_clk = 1'b0;
  logic        tb_rst = 1'b0;
  logic [6:0]  link_data = '0;
  logic        tb_rdy = 1'b1;
  logic        flt_err;
  logic        frm_err;
  logic        sl_ack;
  logic [71:0] pkt_data;
  logic        pkt_vld;

  logic [6:0] nib_sym [16] = '{
    7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
    7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
    7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
    7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001
  };

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ack_toggles = 0;
  int unsigned flt_pulses = 0;
  int unsigned frm_pulses = 0;
  logic        ack_prev = 1'b0;
  time         last_ack_time = 0;
  time         rdy_time = 0;
  logic [71:0] exp_q [$];

  spio_spinnaker_link_receiver dut (
    .CLK_IN          (tb_clk),
    .RESET_IN        (tb_rst),
    .FLT_ERR_OUT     (flt_err),
    .FRM_ERR_OUT     (frm_err),
    .SL_DATA_2OF7_IN (link_data),
    .SL_ACK_OUT      (sl_ack),
    .PKT_DATA_OUT    (pkt_data),
    .PKT_VLD_OUT     (pkt_vld),
    .PKT_RDY_IN      (tb_rdy)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] make_pkt(input logic [7:0] hdr, input logic [31:0] key,
                                           input logic [31:0] pld);
    logic [71:0] p;
    p = '0;
    p[HDR_LSB +: HDR_W] = hdr;
    p[KEY_LSB +: KEY_W] = key;
    p[PLD_LSB +: PLD_W] = pld;
    return p;
  endfunction

  // Monitor: ack/error pulse counting and in-order packet scoreboard
  initial begin
    forever begin
      @(negedge tb_clk);
      if (sl_ack != ack_prev) ack_toggles++;
      ack_prev = sl_ack;
      if (flt_err) flt_pulses++;
      if (frm_err) frm_pulses++;
      if (tb_rst && pkt_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vld", pkt_data, 72'h0);
          checks++;
          errors++;
          $display("FAIL unexpected_vld: got vld=1 expected vld=0");
        end else begin
          check("pkt_data", pkt_data, exp_q[0]);
          if (tb_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_sym(input logic [6:0] sym, input int unsigned budget, input string name);
    logic prev;
    bit   got;
    prev      = sl_ack;
    link_data = link_data ^ sym;
    got       = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      @(negedge tb_clk);
      if (sl_ack != prev) got = 1'b1;
    end
    last_ack_time = $time;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: got no ack toggle expected toggle within %0d cycles", name, budget);
    end
    #10;
  endtask

  task automatic send_nibs(input logic [71:0] pkt, input int unsigned first, input int unsigned count);
    logic [3:0] nib;
    for (int unsigned i = first; i < first + count; i++) begin
      nib = pkt[4*i +: 4];
      send_sym(nib_sym[nib], 20, "ack_flit");
    end
  endtask

  task automatic send_pkt(input logic [71:0] pkt, input int unsigned nflits, input int unsigned eop_budget);
    send_nibs(pkt, 0, nflits);
    send_sym(TB_EOP, eop_budget, "ack_eop");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [71:0] p_short, p_long, p_a, p_b, p_bad, p_fix, p_frm, p_rst;
    int unsigned a0, f0, r0;
    bit          up;

    p_short = 72'h000000000000000100;
    p_long  = 72'hA5A5A5B40000000F42;
    p_a     = make_pkt(8'h00, 32'hDEADBEEF, 32'h0);
    p_b     = make_pkt(8'h80, 32'h12345678, 32'h0);
    p_bad   = make_pkt(8'h00, 32'h11111111, 32'h0);
    p_fix   = make_pkt(8'h02, 32'h89ABCDEF, 32'h01234567);
    p_frm   = make_pkt(8'h00, 32'h00000333, 32'h0);
    p_rst   = make_pkt(8'h01, 32'hCAFEF00D, 32'h0);

    // Reset and ready indication
    tb_rst = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1;
    check("rst_ack", 72'(sl_ack), 72'h0);
    check("rst_vld", 72'(pkt_vld), 72'h0);
    check("rst_data", pkt_data, 72'h0);
    check("rst_flt", 72'(flt_err), 72'h0);
    check("rst_frm", 72'(frm_err), 72'h0);
    tb_rst = 1'b1;
    @(posedge tb_clk);
    #1;
    check("ready_ack", 72'(sl_ack), 72'h1);
    repeat (2) @(posedge tb_clk);

    // Short packet: 10 flits + EOP, 11 ack toggles
    a0 = ack_toggles;
    exp_q.push_back(p_short);
    send_pkt(p_short, 10, 20);
    repeat (3) @(negedge tb_clk);
    check("short_ack_count", 72'(ack_toggles - a0), 72'd11);

    // Long packet
    exp_q.push_back(p_long);
    send_pkt(p_long, 18, 20);
    repeat (5) @(negedge tb_clk);

    // Backpressure: second EOP must wait for the consumer
    @(posedge tb_clk);
    #1;
    tb_rdy = 1'b0;
    exp_q.push_back(p_a);
    exp_q.push_back(p_b);
    fork
      begin
        send_pkt(p_a, 10, 20);
        send_pkt(p_b, 10, 400);
      end
      begin
        repeat (200) @(posedge tb_clk);
        #1;
        check("bp_hold_vld", 72'(pkt_vld), 72'h1);
        check("bp_hold_data", pkt_data, p_a);
        tb_rdy   = 1'b1;
        rdy_time = $time;
      end
    join
    check("bp_eop_withheld", 72'(last_ack_time > rdy_time), 72'h1);
    repeat (5) @(negedge tb_clk);
    check("bp_drained", 72'(exp_q.size()), 72'h0);

    // Illegal symbol drops the packet, next packet is fine
    f0 = flt_pulses;
    r0 = frm_pulses;
    send_nibs(p_bad, 0, 2);
    send_sym(TB_BAD, 20, "ack_bad_sym");
    send_nibs(p_bad, 2, 8);
    send_sym(TB_EOP, 20, "ack_eop_drop");
    repeat (3) @(negedge tb_clk);
    check("flt_pulse", 72'(flt_pulses - f0), 72'd1);
    check("flt_no_frm", 72'(frm_pulses - r0), 72'd0);
    exp_q.push_back(p_fix);
    send_pkt(p_fix, 18, 20);
    repeat (5) @(negedge tb_clk);

    // Short EOP after 5 flits is a framing error
    f0 = flt_pulses;
    r0 = frm_pulses;
    send_pkt(p_frm, 5, 20);
    repeat (3) @(negedge tb_clk);
    check("frm_pulse", 72'(frm_pulses - r0), 72'd1);
    check("frm_no_flt", 72'(flt_pulses - f0), 72'd0);
    exp_q.push_back(p_rst);
    send_pkt(p_rst, 10, 20);
    repeat (5) @(negedge tb_clk);

    // Reset mid-packet discards the partial packet
    send_nibs(72'hFFFFFFFFFFFFFFFFFF, 0, 6);
    @(posedge tb_clk);
    #1;
    tb_rst = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1;
    check("midrst_ack", 72'(sl_ack), 72'h0);
    tb_rst = 1'b1;
    up = 1'b0;
    for (int unsigned i = 0; i < 10 && !up; i++) begin
      @(negedge tb_clk);
      if (sl_ack) up = 1'b1;
    end
    check("midrst_ready", 72'(up), 72'h1);
    exp_q.push_back(p_short);
    send_pkt(p_short, 10, 20);

    repeat (20) @(negedge tb_clk);
    check("scoreboard_empty", 72'(exp_q.size()), 72'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spio_spinnaker_link_receiver.md
Name: spio_spinnaker_link_receiver

Overview:
- Receives SpiNNaker packets over an asynchronous 2-of-7 NRZ SpiNNaker link (7 data wires in, 1 ack wire out).
- Decodes symbols into 4-bit flits and assembles 40-bit (short) or 72-bit (long) packets.
- Presents each packet on a valid/ready parallel interface.
- Sits at the chip-to-FPGA boundary, feeding the internal packet fabric; reports link errors as pulses.

Parameters:
- none

Ports:
- CLK_IN  input  1  system clock; all logic on rising edge
- RESET_IN  input  1  reset, synchronous, active-low
- FLT_ERR_OUT  output  1  one-cycle pulse: illegal 2-of-7 symbol received
- FRM_ERR_OUT  output  1  one-cycle pulse: packet framing/length error
- SL_DATA_2OF7_IN  input  7  asynchronous NRZ 2-of-7 link data
- SL_ACK_OUT  output  1  NRZ ack; each toggle acknowledges one symbol
- PKT_DATA_OUT  output  72  packet: [7:0] header, [39:8] key, [71:40] payload
- PKT_VLD_OUT  output  1  packet valid
- PKT_RDY_IN  input  1  consumer ready; transfer when VLD and RDY on a clock edge

Behaviour:
- Reset (RESET_IN low at a clock edge):
  - SL_ACK_OUT=0, PKT_VLD_OUT=0, PKT_DATA_OUT=0, both error outputs 0.
  - Flit counter cleared; reference ("last") data register loaded from the synchronised input.
  - Reset mid-packet discards any partial packet.
- Ready indication: on the first cycle after reset release, SL_ACK_OUT toggles to 1. The link must not send before seeing this.
- Input capture:
  - SL_DATA_2OF7_IN passes through a 2-flop synchroniser.
  - Each cycle, diff = sync_data XOR last.
  - A symbol is complete when popcount(diff) >= 2.
  - Fewer than 2 changed bits means wait; skew between wires is tolerated this way.
- Decode of diff (nibble value):
  - 0:0010001  1:0010010  2:0010100  3:0011000
  - 4:0100001  5:0100010  6:0100100  7:0101000
  - 8:1000001  9:1000010  10:1000100  11:1001000
  - 12:0000011  13:0000110  14:0001100  15:0001001
  - EOP:1100000
- Illegal symbol: any other pattern with 2 bits changed, or 3+ bits changed.
  - FLT_ERR_OUT pulses; symbol is acked and consumed.
  - Current packet is marked bad and dropped at the next EOP.
- On each consumed symbol: last <= sync_data; SL_ACK_OUT toggles one cycle later (registered). Exactly one toggle per symbol.
- Assembly:
  - Data flit n (counter 0..17) is written to packet bits [4n+3:4n]; first flit = header low nibble.
  - Counter increments per data flit.
  - Data flit with counter already 18: FRM_ERR_OUT pulse; drop until EOP.
- On EOP, length is valid when:
  - counter==10 and header bit1==0 (short), or
  - counter==18 and header bit1==1 (long).
  - Otherwise FRM_ERR_OUT pulses and the packet is dropped.
  - EOP with counter 0 is a framing error.
  - Counter clears on every EOP.
- Parity (header bit0) is not checked; the packet is passed through unmodified. Short packets output payload bits as 0.
- Output: one-entry register.
  - A valid EOP moves the assembled packet into it and sets PKT_VLD_OUT the next cycle.
  - If the register is full and not being consumed that cycle, the EOP ack is withheld until the transfer occurs. This backpressures the link.
  - Data flits are always acked (a separate assembly buffer is used).
  - PKT_DATA_OUT is stable while PKT_VLD_OUT=1 and PKT_RDY_IN=0.
  - VLD clears after transfer unless a new packet loads in the same cycle; back-to-back delivery is allowed.
- Error and drop paths never assert PKT_VLD_OUT.

Decomposition:
- Shared package:
  - packet field ranges (HDR 0+:8, KEY 8+:32, PLD 40+:32)
  - short/long flit counts 10/18
  - EOP code 7'b1100000
  - the 2-of-7 symbol table constants
- Sub-module: spio_spinnaker_link_sync (2-flop synchroniser, parameterised width). Decode and assembly stay in the top level.

Test Plan:
- Reset, then release -> SL_ACK_OUT 0 in reset, rises to 1 one cycle after release.
- Short packet:
  - Stimulus: hdr 0x00, key 0x00000001; nibbles 0,0,1,0,0,0,0,0,0,0 then EOP, 10 ns handshake delay.
  - Response: 11 ack toggles; PKT_DATA_OUT[39:0]=0x0000000100 with VLD=1.
- Long packet:
  - Stimulus: type bit set, payload flag set, key 0x0000000F, payload 0xA5A5A5B4 (18 nibbles + EOP).
  - Response: header/key/payload match exactly.
- Backpressure:
  - Stimulus: PKT_RDY_IN=0 for 200 cycles while two packets are sent.
  - Response: first packet held stable; second EOP ack withheld until RDY=1; both delivered in order, no loss.
- Errors:
  - Diff 0000111 -> FLT_ERR_OUT pulse, ack still toggles, packet dropped.
  - EOP after 5 flits -> FRM_ERR_OUT pulse, no VLD.
  - The next good packet is received correctly in both cases.
- Reset mid-packet:
  - Stimulus: assert reset after 6 flits, then send a full short packet.
  - Response: only the full packet is output.
